// File: rtl/iir_fb.sv
// Recursive (denominator) half of the IIR filter: y[n] = x[n] - sum a[k]*y[n-1-k],
// evaluated one tap per cycle on a single shared multiply-accumulate.
module iir_fb #(
    parameter int PRECISION   = 16,
    parameter int COEFF_WIDTH = 16,
    parameter int N           = 4,
    parameter int FRAC_BITS   = 14
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          clear,
    input  logic                          x_valid,
    output logic                          x_ready,
    input  logic signed [PRECISION-1:0]   x,
    input  logic [COEFF_WIDTH*N-1:0]      packed_a_coeffs,
    output logic                          y_valid,
    output logic signed [PRECISION-1:0]   y
);

    localparam int AW = PRECISION + COEFF_WIDTH + $clog2(N + 1) + 1;
    localparam int PW = PRECISION + COEFF_WIDTH;
    localparam int KW = (N > 1) ? $clog2(N) : 1;

    localparam logic signed [AW-1:0] ROUND = AW'(1) << (FRAC_BITS - 1);
    localparam logic signed [AW-1:0] Y_MAX = (AW'(1) << (PRECISION - 1)) - AW'(1);
    localparam logic signed [AW-1:0] Y_MIN = ~Y_MAX;

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        OUT
    } state_t;

    state_t state;
    state_t state_next;

    logic [KW-1:0]                 k;
    logic                          k_last;
    logic                          accept;
    logic signed [COEFF_WIDTH-1:0] a_reg [N];
    logic signed [PRECISION-1:0]   y_dly [N];
    logic signed [AW-1:0]          acc;
    logic signed [AW-1:0]          x_ext;
    logic signed [PW-1:0]          prod;
    logic signed [AW-1:0]          prod_ext;
    logic signed [AW-1:0]          acc_round;
    logic signed [AW-1:0]          acc_shift;
    logic signed [PRECISION-1:0]   y_sat;

    assign k_last   = (k == KW'(N - 1));
    assign accept   = x_valid & x_ready;
    assign x_ext    = {{(AW - PRECISION){x[PRECISION-1]}}, x};
    assign prod     = a_reg[k] * y_dly[k];
    assign prod_ext = {{(AW - PW){prod[PW-1]}}, prod};
    assign acc_round = acc + ROUND;
    assign acc_shift = acc_round >>> FRAC_BITS;

    always_comb begin
        if (acc_shift > Y_MAX) begin
            y_sat = {1'b0, {(PRECISION - 1){1'b1}}};
        end else if (acc_shift < Y_MIN) begin
            y_sat = {1'b1, {(PRECISION - 1){1'b0}}};
        end else begin
            y_sat = acc_shift[PRECISION-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else if (clear) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // OUT also accepts, so back-to-back samples cost exactly N+1 cycles each
    always_comb begin
        state_next = state;
        x_ready    = 1'b0;
        case (state)
            IDLE: begin
                x_ready = 1'b1;
                if (x_valid) begin
                    state_next = MAC;
                end
            end
            MAC: begin
                if (k_last) begin
                    state_next = OUT;
                end
            end
            OUT: begin
                x_ready    = 1'b1;
                state_next = x_valid ? MAC : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc     <= '0;
            k       <= '0;
            y       <= '0;
            y_valid <= 1'b0;
            for (int i = 0; i < N; i++) begin
                a_reg[i] <= '0;
                y_dly[i] <= '0;
            end
        end else if (clear) begin
            acc     <= '0;
            k       <= '0;
            y_valid <= 1'b0;
            for (int i = 0; i < N; i++) begin
                y_dly[i] <= '0;
            end
        end else begin
            y_valid <= 1'b0;
            case (state)
                MAC: begin
                    acc <= acc - prod_ext;
                    k   <= k_last ? '0 : k + 1'b1;
                end
                OUT: begin
                    y        <= y_sat;
                    y_valid  <= 1'b1;
                    y_dly[0] <= y_sat;
                    for (int i = 1; i < N; i++) begin
                        y_dly[i] <= y_dly[i-1];
                    end
                end
                default: ;
            endcase
            // coefficients are frozen per sample so mid-flight changes cannot corrupt it
            if (accept) begin
                acc <= x_ext <<< FRAC_BITS;
                k   <= '0;
                for (int i = 0; i < N; i++) begin
                    a_reg[i] <= packed_a_coeffs[COEFF_WIDTH*i +: COEFF_WIDTH];
                end
            end
        end
    end

endmodule

// File: tb/tb_iir_fb.sv
// Self-checking bench for iir_fb: directed scenarios plus randomized samples
// compared against a plain-arithmetic recurrence model.
module tb_iir_fb;

    localparam int P  = 16;
    localparam int C  = 16;
    localparam int NT = 4;
    localparam int F  = 14;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               clear;
    logic               x_valid;
    logic               x_ready;
    logic signed [P-1:0] x;
    logic [C*NT-1:0]    packed_a_coeffs;
    logic               y_valid;
    logic signed [P-1:0] y;

    int     total = 0;
    int     bad   = 0;
    longint hist [NT];
    longint modelLastY;

    always #5 clk = ~clk;

    iir_fb #(
        .PRECISION  (P),
        .COEFF_WIDTH(C),
        .N          (NT),
        .FRAC_BITS  (F)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .clear          (clear),
        .x_valid        (x_valid),
        .x_ready        (x_ready),
        .x              (x),
        .packed_a_coeffs(packed_a_coeffs),
        .y_valid        (y_valid),
        .y              (y)
    );

    task automatic checkOutput(input string tag, input longint obs, input longint exp);
        total++;
        if (obs != exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [C*NT-1:0] packCoeffs(input int a0, input int a1, input int a2, input int a3);
        return {C'(a3), C'(a2), C'(a1), C'(a0)};
    endfunction

    function automatic longint coeffOf(input logic [C*NT-1:0] p, input int k);
        logic signed [C-1:0] c;
        c = p[C*k +: C];
        return longint'(c);
    endfunction

    // y = sat(round((x*2^F - sum a[k]*y[n-1-k]) / 2^F)), then push y into history
    function automatic longint modelStep(input longint xv, input logic [C*NT-1:0] p);
        longint acc;
        longint r;
        acc = xv * (longint'(1) << F);
        for (int k = 0; k < NT; k++) begin
            acc = acc - coeffOf(p, k) * hist[k];
        end
        r = (acc + (longint'(1) << (F - 1))) >>> F;
        if (r > 32767) r = 32767;
        if (r < -32768) r = -32768;
        for (int k = NT - 1; k > 0; k--) begin
            hist[k] = hist[k-1];
        end
        hist[0] = r;
        modelLastY = r;
        return r;
    endfunction

    task automatic modelClear();
        for (int k = 0; k < NT; k++) begin
            hist[k] = 0;
        end
    endtask

    task automatic doClear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        modelClear();
    endtask

    task automatic acceptSample(input longint xv, input logic [C*NT-1:0] coeffs, output bit ok);
        x               = xv[P-1:0];
        packed_a_coeffs = coeffs;
        x_valid         = 1'b1;
        ok              = 1'b0;
        for (int t = 0; t < 40; t++) begin
            if (x_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (ok) begin
            @(posedge clk);
            #1 x_valid = 1'b0;
        end else begin
            x_valid = 1'b0;
            checkOutput("accept_timeout", 0, 1);
        end
    endtask

    task automatic applyStimulus(input longint xv, input logic [C*NT-1:0] coeffs,
                                 input bit changeMid, input logic [C*NT-1:0] newCoeffs,
                                 output longint yOut);
        bit     ok;
        bit     seen;
        longint expY;
        acceptSample(xv, coeffs, ok);
        expY = modelStep(xv, coeffs);
        seen = 1'b0;
        yOut = 0;
        if (ok) begin
            for (int i = 0; i < 12; i++) begin
                @(negedge clk);
                if (y_valid) begin
                    checkOutput("latency", i, NT + 1);
                    checkOutput("y", y, expY);
                    yOut = y;
                    seen = 1'b1;
                    break;
                end
                if (changeMid && i == 1) packed_a_coeffs = newCoeffs;
            end
            if (!seen) checkOutput("y_valid_timeout", 0, 1);
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [C*NT-1:0] cA;
        logic [C*NT-1:0] cB;
        longint          yo;
        bit              ok;
        int              cnt;
        int              dec [5];
        logic [31:0]     r;

        dec = '{16384, 8192, 4096, 2048, 1024};
        modelClear();
        modelLastY = 0;

        // reset held with a pending valid: nothing may be accepted
        rst_n = 1'b0;
        clear = 1'b0;
        x_valid = 1'b1;
        x = 16'sd1234;
        packed_a_coeffs = '0;
        repeat (3) begin
            @(negedge clk);
            checkOutput("rst_x_ready", x_ready, 1);
            checkOutput("rst_y_valid", y_valid, 0);
            checkOutput("rst_y", y, 0);
        end
        x_valid = 1'b0;
        rst_n = 1'b1;
        cnt = 0;
        repeat (NT + 3) begin
            @(negedge clk);
            if (y_valid) cnt++;
        end
        checkOutput("rst_no_accept", cnt, 0);
        checkOutput("rst_ready_after", x_ready, 1);

        $display("[TB] decay");
        doClear();
        cA = packCoeffs(-8192, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus((i == 0) ? 16384 : 0, cA, 1'b0, cA, yo);
            checkOutput($sformatf("decay_%0d", i), yo, dec[i]);
        end

        $display("[TB] saturation");
        doClear();
        cA = packCoeffs(-16384, 0, 0, 0);
        applyStimulus(20000, cA, 1'b0, cA, yo);
        checkOutput("sat_first", yo, 20000);
        applyStimulus(20000, cA, 1'b0, cA, yo);
        checkOutput("sat_pos", yo, 32767);
        applyStimulus(20000, cA, 1'b0, cA, yo);
        checkOutput("sat_pos_hold", yo, 32767);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(-20000, cA, 1'b0, cA, yo);
        end
        checkOutput("sat_neg", yo, -32768);

        $display("[TB] handshake");
        doClear();
        packed_a_coeffs = '0;
        x = 16'sd100;
        x_valid = 1'b1;
        checkOutput("hs_ready_pre", x_ready, 1);
        @(posedge clk);
        for (int i = 0; i <= 11; i++) begin
            @(negedge clk);
            if (i == 0) x = 16'sd200;
            if (i == 5) x_valid = 1'b0;
            checkOutput($sformatf("hs_ready_%0d", i), x_ready,
                        ((i <= 3) || (i >= 5 && i <= 8)) ? 0 : 1);
            checkOutput($sformatf("hs_valid_%0d", i), y_valid, (i == 5 || i == 10) ? 1 : 0);
            if (i == 5) checkOutput("hs_y0", y, 100);
            if (i == 10) checkOutput("hs_y1", y, 200);
        end
        yo = modelStep(100, '0);
        yo = modelStep(200, '0);

        $display("[TB] clear mid-MAC");
        cA = packCoeffs(-8192, -8192, -8192, -8192);
        acceptSample(5000, cA, ok);
        @(negedge clk);
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        cnt = 0;
        repeat (8) begin
            if (y_valid) cnt++;
            @(negedge clk);
        end
        checkOutput("clr_no_y_valid", cnt, 0);
        checkOutput("clr_y_held", y, modelLastY);
        checkOutput("clr_ready", x_ready, 1);
        modelClear();
        applyStimulus(16384, cA, 1'b0, cA, yo);
        checkOutput("clr_impulse", yo, 16384);

        $display("[TB] coefficient change in flight");
        doClear();
        cA = packCoeffs(-8192, 4096, 0, 0);
        cB = packCoeffs(3000, -3000, 2000, 1000);
        applyStimulus(10000, cA, 1'b0, cA, yo);
        applyStimulus(8000, cA, 1'b1, cB, yo);
        applyStimulus(-5000, cB, 1'b0, cB, yo);
        applyStimulus(1234, cB, 1'b0, cB, yo);

        $display("[TB] random");
        doClear();
        cA = packCoeffs(0, 0, 0, 0);
        for (int n = 0; n < 40; n++) begin
            if (n % 10 == 0) begin
                cA = packCoeffs(int'($urandom_range(0, 8000)) - 4000, int'($urandom_range(0, 8000)) - 4000,
                                int'($urandom_range(0, 8000)) - 4000, int'($urandom_range(0, 8000)) - 4000);
                if (n != 0) doClear();
            end
            cB = packCoeffs(int'($urandom_range(0, 8000)) - 4000, int'($urandom_range(0, 8000)) - 4000,
                            int'($urandom_range(0, 8000)) - 4000, int'($urandom_range(0, 8000)) - 4000);
            r = $urandom;
            applyStimulus(longint'($signed(r[15:0])), cA, ($urandom_range(0, 3) == 0), cB, yo);
            cA = packed_a_coeffs;
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
